regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_ctrl.sv | 40 ++++
 rtl/regfile_mp.sv | 96 +++++++++
 tb/tb_regfile_mp.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and legal parameter ranges for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RD_PORTS_MIN = 1;
  localparam int RD_PORTS_MAX = 4;
  localparam int WR_PORTS_MIN = 1;
  localparam int WR_PORTS_MAX = 2;

endpackage : regfile_pkg

// File: rtl/regfile_clear_ctrl.sv
// Sweep controller: after reset, walks every address once so the array can be
// zeroed one entry per cycle, holding busy until the last entry is written.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 ** ADDR_W) - 1);

  state_t state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == LAST_ADDR) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY:   busy <= 1'b0;
        default: state <= CLEAR;
      endcase
    end
  end

endmodule : regfile_clear_ctrl

// File: rtl/regfile_mp.sv
// Multi-port register file with sequential clear sweep, same-cycle write
// bypass on reads, optional hardwired-zero register 0 and conflict flag.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic                     busy,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (NUM_RD < RD_PORTS_MIN || NUM_RD > RD_PORTS_MAX) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD=%0d outside legal range", NUM_RD);
  end
  if (NUM_WR < WR_PORTS_MIN || NUM_WR > WR_PORTS_MAX) begin : g_bad_num_wr
    $error("regfile_mp: NUM_WR=%0d outside legal range", NUM_WR);
  end

  logic              sweep_busy;
  logic [ADDR_W-1:0] clr_cnt;
  logic              conflict_now;
  logic [DATA_W-1:0] mem [DEPTH];

  regfile_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
    .clk    (clk),
    .rst    (rst),
    .busy   (sweep_busy),
    .clr_cnt(clr_cnt)
  );

  // rst is folded in so the block reads as busy before the first reset edge.
  assign busy = sweep_busy | rst;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // NOTE: the array has no reset branch; contents are cleared only by the
  // sweep, which keeps this a plain RAM-style write path.
  always_ff @(posedge clk) begin
    if (busy) begin
      if (!rst) mem[clr_cnt] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && !is_zero_reg(wa[j*ADDR_W +: ADDR_W]))
          mem[wa[j*ADDR_W +: ADDR_W]] <= wd[j*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd[i*DATA_W +: DATA_W] = mem[ra[i*ADDR_W +: ADDR_W]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (wa[j*ADDR_W +: ADDR_W] == ra[i*ADDR_W +: ADDR_W]))
          rd[i*DATA_W +: DATA_W] = wd[j*DATA_W +: DATA_W];
      end
      if (busy || is_zero_reg(ra[i*ADDR_W +: ADDR_W]))
        rd[i*DATA_W +: DATA_W] = '0;
    end
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (we[j] && we[k] &&
            (wa[j*ADDR_W +: ADDR_W] == wa[k*ADDR_W +: ADDR_W]) &&
            !is_zero_reg(wa[j*ADDR_W +: ADDR_W]))
          conflict_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_conflict <= 1'b0;
    else     wr_conflict <= conflict_now && !busy;
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: the driver queues expected values per cycle,
// an independent monitor pops and compares them on the falling edge.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  localparam int SIG_RD0  = 0;
  localparam int SIG_RD1  = 1;
  localparam int SIG_BUSY = 2;
  localparam int SIG_CONF = 3;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] wa;
  logic [NUM_WR*DATA_W-1:0] wd;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic                     busy;
  logic                     wr_conflict;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .busy(busy), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every expectation tagged with the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sig)
        SIG_RD0:  act = rd[0*DATA_W +: DATA_W];
        SIG_RD1:  act = rd[1*DATA_W +: DATA_W];
        SIG_BUSY: act = {31'd0, busy};
        default:  act = {31'd0, wr_conflict};
      endcase
      if (e.cyc != cyc) check({e.name, " (stale)"}, act, ~e.val);
      else              check(e.name, act, e.val);
    end
  end

  task automatic expect_val(input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] we_v,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1);
    we = we_v;
    wa = {a1, a0};
    wd = {d1, d0};
    ra = {r1, r0};
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd31, 5'd20);

    // Reset held: busy high and reads forced to zero.
    step();
    expect_val(SIG_BUSY, 32'd1, "busy_in_rst");
    expect_val(SIG_RD0, 32'd0, "rd0_in_rst");
    expect_val(SIG_CONF, 32'd0, "conf_in_rst");
    step();
    rst = 1'b0;

    // Sweep: 32 busy cycles, with a dual write to r20 at sweep cycle 5.
    for (int k = 0; k < 32; k++) begin
      if (k == 5) drive(2'b11, 5'd20, 32'h11, 5'd20, 32'h11, 5'd31, 5'd20);
      else        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd31, 5'd20);
      expect_val(SIG_BUSY, 32'd1, $sformatf("sweep_busy_%0d", k));
      expect_val(SIG_RD0, 32'd0, $sformatf("sweep_rd0_%0d", k));
      if (k == 6) expect_val(SIG_CONF, 32'd0, "conf_while_busy");
      step();
    end
    expect_val(SIG_BUSY, 32'd0, "busy_done");
    expect_val(SIG_RD0, 32'd0, "r31_cleared");
    expect_val(SIG_RD1, 32'd0, "r20_write_ignored");

    // Bypass: write r9=5 and read it on both ports in the same cycle.
    step();
    drive(2'b01, 5'd9, 32'd5, 5'd0, 32'd0, 5'd9, 5'd9);
    expect_val(SIG_RD0, 32'd5, "bypass_rd0");
    expect_val(SIG_RD1, 32'd5, "bypass_rd1");
    step();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9);
    expect_val(SIG_RD0, 32'd5, "r9_stored");

    // Dual write to r10: port 1 wins, conflict pulses for one cycle.
    step();
    drive(2'b11, 5'd10, 32'd7, 5'd10, 32'd3, 5'd10, 5'd9);
    expect_val(SIG_RD0, 32'd3, "conflict_bypass");
    expect_val(SIG_CONF, 32'd0, "conf_same_cycle");
    step();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd10, 5'd10);
    expect_val(SIG_RD0, 32'd3, "r10_port1_wins");
    expect_val(SIG_CONF, 32'd1, "conf_pulse");
    step();
    expect_val(SIG_CONF, 32'd0, "conf_one_cycle");

    // Zero register: writes dropped, bypass suppressed.
    step();
    drive(2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'd0, 5'd0, 5'd0);
    expect_val(SIG_RD0, 32'd0, "r0_bypass_zero");
    expect_val(SIG_RD1, 32'd0, "r0_bypass_zero_rd1");
    step();
    drive(2'b11, 5'd0, 32'h1234, 5'd0, 32'h5678, 5'd0, 5'd9);
    expect_val(SIG_RD0, 32'd0, "r0_after_write");
    step();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd9);
    expect_val(SIG_CONF, 32'd0, "conf_r0_excluded");
    expect_val(SIG_RD0, 32'd0, "r0_still_zero");

    // Distinct-address dual write, independent read ports.
    step();
    drive(2'b11, 5'd13, 32'h1313, 5'd14, 32'h1414, 5'd13, 5'd14);
    expect_val(SIG_RD0, 32'h1313, "dual_bypass_rd0");
    expect_val(SIG_RD1, 32'h1414, "dual_bypass_rd1");
    step();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd14, 5'd13);
    expect_val(SIG_RD0, 32'h1414, "r14_stored");
    expect_val(SIG_RD1, 32'h1313, "r13_stored");
    expect_val(SIG_CONF, 32'd0, "conf_distinct");

    // Mid-sweep reset: restart at sweep cycle 12, then 32 full busy cycles.
    step();
    rst = 1'b1;
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd10);
    step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      expect_val(SIG_BUSY, 32'd1, $sformatf("pre_restart_busy_%0d", k));
      expect_val(SIG_RD0, 32'd0, $sformatf("pre_restart_rd0_%0d", k));
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      expect_val(SIG_BUSY, 32'd1, $sformatf("restart_busy_%0d", k));
      step();
    end
    expect_val(SIG_BUSY, 32'd0, "restart_done");
    expect_val(SIG_RD0, 32'd0, "r9_cleared");
    expect_val(SIG_RD1, 32'd0, "r10_cleared");
    ra = {5'd13, 5'd14};
    step();
    expect_val(SIG_RD0, 32'd0, "r14_cleared");
    expect_val(SIG_RD1, 32'd0, "r13_cleared");

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 4 && sb.size() > 0; t++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_mp
